regwb_sched: RTL
================

# regwb_sched

Writeback scheduler for the dual-write-port register memory used by the dual-issue pipeline. It maps writebacks from issue slot 0, issue slot 1 and the load unit onto the two register-file write ports. Loads are buffered in a small queue and drained into idle port slots. The block also keeps a per-register pending-load scoreboard for the hazard unit and suppresses write-after-write hazards, both within a cycle and against queued loads.

## Interface

- LDQ_DEPTH, 2, load queue entries (2..8)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- s0_valid / s0_reg / s0_data  in  1/5/32  slot-0 ALU writeback; never stalled
- s1_valid / s1_reg / s1_data  in  1/5/32  slot-1 ALU writeback; younger than slot 0; never stalled
- ld_valid / ld_reg / ld_data  in  1/5/32  load-unit writeback request
- ld_ready  out  1  load accepted when ld_valid && ld_ready
- alloc_valid / alloc_reg  in  1/5  issue stage allocating a load destination
- ld_busy  out  32  bit n set = load to register n outstanding
- regwrite / wrreg / wrdata  out  1/5/32  write port 0 to register memory
- regwrite1 / wrreg1 / wrdata1  out  1/5/32  write port 1 to register memory
- stat_stall / stat_drop  out  16/16  statistics counters (see Configuration)

## Operation

- Register 0: requests to reg 0 are accepted but never produce regwrite; reg 0 is never set in ld_busy.
- Port 0 carries slot 0 and port 1 carries slot 1, combinationally and with zero latency.
- Same-cycle collision: if s0 and s1 are valid with equal reg, port 0 is suppressed (regwrite=0) and only slot 1 is written.
- Load queue: FIFO of {reg, data, stale}, LDQ_DEPTH entries. An accepted load is enqueued at the edge. ld_ready = !full and is registered-state only, with no same-cycle pass-through when full.
- Drain: a non-stale head is written on port 0 if s0_valid=0, else on port 1 if s1_valid=0, else it waits. Pops at that edge.
- WAW against loads: ALU writes are always younger than any outstanding load.
  - Each valid s0/s1 write to reg X marks every queue entry with reg X stale, including a load being enqueued in the same cycle.
  - A stale head pops without using a port, even when both ports are busy, and increments stat_drop.
- Scoreboard: alloc sets ld_busy[alloc_reg]. A popped entry, written or dropped, clears ld_busy[reg]. If set and clear hit the same register in one cycle, the set wins.
- The issue stage guarantees at most one outstanding load per destination register; the block does not check this.

## Timing

- Reset (async, rst_n low):
  - Queue is empty; ld_busy=0; counters are 0; ld_ready=1.
  - regwrite, regwrite1, wrreg, wrreg1, wrdata and wrdata1 are all forced to 0 while rst_n is low.
- Reset mid-operation discards all queued loads without writing them.
- ALU writeback latency is 0 cycles (combinational).
- Load latency is at least 1 cycle from acceptance to regwrite. It stretches by one cycle for each cycle in which both slots are valid.
- The queue pointers wrap modulo LDQ_DEPTH. Enqueue and pop in the same cycle keep the count unchanged.

## Configuration

- REGWB_STAT_EN defined: 16-bit saturating counters.
  - stat_stall counts cycles with ld_valid && !ld_ready.
  - stat_drop counts stale pops.
- REGWB_STAT_EN undefined: the counters are not built and both ports are tied to 0.

## Structure

- Package regwb_pkg holds:
  - REG_W=5 and DATA_W=32
  - the ldq_entry_t typedef {reg, data, stale}
  - the REG_ZERO constant
- Sub-module regwb_ldq is the parameterised FIFO. It provides a broadcast stale-mark input (two reg/valid pairs) plus head/pop/full/empty.
- The top level holds the port mux, the scoreboard and the counters.

## Test plan

- Reset: hold rst_n=0 with s0_valid=1 -> regwrite=0, ld_ready=1, ld_busy=0. Release -> slot 0 writes at once.
- Dual write: s0 r3=0x11 and s1 r4=0x22 in the same cycle -> port 0 shows r3/0x11 and port 1 shows r4/0x22 in that cycle.
- Collision: s0 r5=0xA and s1 r5=0xB -> regwrite=0; port 1 writes r5=0xB.
- Queued load:
  - Stimulus: alloc r7; load r7=0x77 accepted while s0 and s1 are valid (other regs) for 3 cycles, then s0 idles.
  - Response: regwrite on port 0 with r7=0x77 in the first idle cycle; ld_busy[7] clears at that edge.
- Full: with LDQ_DEPTH=2, both slots valid continuously and 3 loads offered -> ld_ready=0 after 2 accepts. With REGWB_STAT_EN, stat_stall increments once per blocked cycle.
- Stale drop:
  - Stimulus: alloc r9; load r9=0x99 queued; s1 writes r9=0x5 before the drain.
  - Response: 0x99 is never written; ld_busy[9] clears; stat_drop=1.

Source files
------------

// File: rtl/regwb_pkg.sv
// Shared widths, the load-queue entry type and the WAW match helper for the
// writeback scheduler (regwb_sched, regwb_ldq).
package regwb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_W-1:0]  regnum;
        logic [DATA_W-1:0] data;
        logic              stale;
    } ldq_entry_t;

    // A valid ALU write to r makes any older load to r obsolete; r0 never hazards.
    function automatic logic waw_hit(input logic [REG_W-1:0] r,
                                     input logic             v0,
                                     input logic [REG_W-1:0] r0,
                                     input logic             v1,
                                     input logic [REG_W-1:0] r1);
        return (r != REG_ZERO) && ((v0 && (r0 == r)) || (v1 && (r1 == r)));
    endfunction

endpackage

// File: rtl/regwb_ldq.sv
// Load writeback FIFO with a broadcast stale-mark port: every entry (and the
// entry being pushed) whose register matches a valid mark becomes stale.
module regwb_ldq
    import regwb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [REG_W-1:0]  push_reg_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              mark0_valid_i,
    input  logic [REG_W-1:0]  mark0_reg_i,
    input  logic              mark1_valid_i,
    input  logic [REG_W-1:0]  mark1_reg_i,
    output ldq_entry_t        head_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    ldq_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // The head already counts as stale in the cycle an ALU write hits it, so
    // an older load can never share a cycle with a younger write to its register.
    always_comb begin
        head_o       = mem_q[rd_ptr_q];
        head_o.stale = mem_q[rd_ptr_q].stale
                     || waw_hit(mem_q[rd_ptr_q].regnum, mark0_valid_i, mark0_reg_i,
                                mark1_valid_i, mark1_reg_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waw_hit(mem_q[i].regnum, mark0_valid_i, mark0_reg_i,
                            mark1_valid_i, mark1_reg_i)) begin
                    mem_q[i].stale <= 1'b1;
                end
            end
            if (do_push) begin
                mem_q[wr_ptr_q] <= '{regnum: push_reg_i,
                                     data:   push_data_i,
                                     stale:  waw_hit(push_reg_i, mark0_valid_i, mark0_reg_i,
                                                     mark1_valid_i, mark1_reg_i)};
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/regwb_sched.sv
// Writeback scheduler: maps slot 0, slot 1 and queued loads onto two register
// write ports, tracks pending loads. Statistics counters built with REGWB_STAT_EN.
module regwb_sched
    import regwb_pkg::*;
#(
    parameter int LDQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid,
    input  logic [REG_W-1:0]  s0_reg,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s1_valid,
    input  logic [REG_W-1:0]  s1_reg,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              ld_valid,
    input  logic [REG_W-1:0]  ld_reg,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_reg,
    output logic [31:0]       ld_busy,
    output logic              regwrite,
    output logic [REG_W-1:0]  wrreg,
    output logic [DATA_W-1:0] wrdata,
    output logic              regwrite1,
    output logic [REG_W-1:0]  wrreg1,
    output logic [DATA_W-1:0] wrdata1,
    output logic [15:0]       stat_stall,
    output logic [15:0]       stat_drop
);

    ldq_entry_t  head;
    logic        q_full;
    logic        q_empty;
    logic        head_live;
    logic        pop;
    logic        ld_push;
    logic        s0_wins;
    logic [31:0] ld_busy_q;
    logic [31:0] ld_busy_d;

    // Load handshake: a load transfers at the rising edge where ld_valid && ld_ready;
    // ld_ready is a function of registered occupancy only and never of ld_valid.
    assign ld_ready  = !q_full;
    assign ld_push   = ld_valid && ld_ready;
    assign head_live = !q_empty && !head.stale;
    assign pop       = !q_empty && (head.stale || !s0_valid || !s1_valid);
    assign s0_wins   = !(s1_valid && (s1_reg == s0_reg));

    regwb_ldq #(.DEPTH(LDQ_DEPTH)) u_ldq (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (ld_push),
        .push_reg_i   (ld_reg),
        .push_data_i  (ld_data),
        .pop_i        (pop),
        .mark0_valid_i(s0_valid),
        .mark0_reg_i  (s0_reg),
        .mark1_valid_i(s1_valid),
        .mark1_reg_i  (s1_reg),
        .head_o       (head),
        .full_o       (q_full),
        .empty_o      (q_empty)
    );

    always_comb begin
        regwrite  = 1'b0;
        wrreg     = '0;
        wrdata    = '0;
        regwrite1 = 1'b0;
        wrreg1    = '0;
        wrdata1   = '0;
        if (rst_n) begin
            if (s0_valid) begin
                regwrite = s0_wins && (s0_reg != REG_ZERO);
                wrreg    = s0_reg;
                wrdata   = s0_data;
            end else if (head_live) begin
                regwrite = (head.regnum != REG_ZERO);
                wrreg    = head.regnum;
                wrdata   = head.data;
            end
            if (s1_valid) begin
                regwrite1 = (s1_reg != REG_ZERO);
                wrreg1    = s1_reg;
                wrdata1   = s1_data;
            end else if (head_live && s0_valid) begin
                regwrite1 = (head.regnum != REG_ZERO);
                wrreg1    = head.regnum;
                wrdata1   = head.data;
            end
        end
    end

    // Allocation is applied after the pop clear so a same-register set wins.
    always_comb begin
        ld_busy_d = ld_busy_q;
        if (pop) begin
            ld_busy_d[head.regnum] = 1'b0;
        end
        if (alloc_valid && (alloc_reg != REG_ZERO)) begin
            ld_busy_d[alloc_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_busy_q <= '0;
        end else begin
            ld_busy_q <= ld_busy_d;
        end
    end

    assign ld_busy = ld_busy_q;

`ifdef REGWB_STAT_EN
    logic [15:0] stall_q;
    logic [15:0] drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            if (ld_valid && !ld_ready && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (pop && head.stale && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign stat_stall = stall_q;
    assign stat_drop  = drop_q;
`else
    assign stat_stall = '0;
    assign stat_drop  = '0;
`endif

endmodule
